// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: time-shares one 4-bit magnitude comparator
// among NREQ valid/ready requesters, one compare in flight.
module comparator_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);
  assign gt = a > b;
  assign eq = a == b;
  assign lt = a < b;
endmodule

module cmp_share_arbiter #(
  parameter  int NREQ = 4,
  parameter  bit RR   = 1'b1,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_gt,
  output logic              rsp_eq,
  output logic              rsp_lt,
  output logic              busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] sel;
  logic           gnt_vld;
  logic           accept;
  logic [3:0]     op_a;
  logic [3:0]     op_b;
  logic [IDW-1:0] op_id;
  logic           c_gt;
  logic           c_eq;
  logic           c_lt;
  int             idx;

  // Scan starting at rr_ptr (or 0), wrapping at NREQ.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = k + (RR ? int'(rr_ptr) : 0);
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IDW'(idx);
      if (!gnt_vld && req_valid[sel]) begin
        gnt_vld = 1'b1;
        gnt     = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_vld) state_nxt = CMP;
      CMP:     state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rst_n gates the strobe so no accept is offered while held in reset.
  always_comb begin
    req_ready = '0;
    busy      = 1'b1;
    accept    = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        busy   = 1'b0;
        accept = gnt_vld & rst_n;
        if (accept) req_ready[gnt] = 1'b1;
      end
      default: ;
    endcase
  end

  comparator_4bit u_cmp (
    .a  (op_a),
    .b  (op_b),
    .gt (c_gt),
    .eq (c_eq),
    .lt (c_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_gt    <= 1'b0;
      rsp_eq    <= 1'b0;
      rsp_lt    <= 1'b0;
    end else begin
      if (accept) begin
        op_a   <= req_a[4*gnt +: 4];
        op_b   <= req_b[4*gnt +: 4];
        op_id  <= gnt;
        rr_ptr <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1;
      end
      if (state == CMP) begin
        rsp_valid <= 1'b1;
        rsp_id    <= op_id;
        rsp_gt    <= c_gt;
        rsp_eq    <= c_eq;
        rsp_lt    <= c_lt;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: vector table, corner sequences and a
// transaction-level model driven by random requesters.
module tb_cmp_share_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [4*N-1:0] req_a = '0;
  logic [4*N-1:0] req_b = '0;
  logic           rsp_ready = 1'b0;

  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [W-1:0]   rsp_id;
  logic           rsp_gt;
  logic           rsp_eq;
  logic           rsp_lt;
  logic           busy;

  logic [N-1:0]   fp_req_ready;
  logic           fp_rsp_valid;
  logic [W-1:0]   fp_rsp_id;
  logic           fp_rsp_gt;
  logic           fp_rsp_eq;
  logic           fp_rsp_lt;
  logic           fp_busy;

  cmp_share_arbiter #(.NREQ(N), .RR(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_eq    (rsp_eq),
    .rsp_lt    (rsp_lt),
    .busy      (busy)
  );

  cmp_share_arbiter #(.NREQ(N), .RR(1'b0)) dut_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (fp_req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (fp_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (fp_rsp_id),
    .rsp_gt    (fp_rsp_gt),
    .rsp_eq    (fp_rsp_eq),
    .rsp_lt    (fp_rsp_lt),
    .busy      (fp_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         id;
    int         a;
    int         b;
    logic [2:0] gel;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input int a, input int b);
    return {a > b, a == b, a < b};
  endfunction

  function automatic logic [10:0] outs();
    return {req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy};
  endfunction

  function automatic logic [10:0] fp_outs();
    return {fp_req_ready, fp_rsp_valid, fp_rsp_id,
            fp_rsp_gt, fp_rsp_eq, fp_rsp_lt, fp_busy};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Entered and left at posedge+1 with the block idle, rsp_ready=1.
  task automatic do_single(input int id, input int a, input int b,
                           input logic [2:0] gel);
    logic [N-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    req_valid = oh;
    req_a[4*id +: 4] = 4'(a);
    req_b[4*id +: 4] = 4'(b);
    @(negedge clk);
    chk("grant", 32'(req_ready), 32'(oh));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("cmp_phase", 32'({req_ready, rsp_valid, busy}), 32'(6'b000001));
    @(posedge clk); #1;
    @(negedge clk);
    chk("result", 32'({rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt}),
        32'({1'b1, W'(id), gel}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("retire", 32'({rsp_valid, busy}), 32'(0));
    @(posedge clk); #1;
  endtask

  logic [N-1:0] e_rdy;
  logic [N-1:0] f_rdy;
  logic [N-1:0] acc;
  int           g;
  int           m_ptr;
  int           m_age;
  int           m_id;
  int           m_a;
  int           m_b;
  bit           m_busy;

  initial begin
    vecs[0] = '{2, 5, 3, 3'b100};
    vecs[1] = '{2, 8, 8, 3'b010};
    vecs[2] = '{2, 2, 14, 3'b001};
    vecs[3] = '{0, 15, 0, 3'b100};
    vecs[4] = '{1, 0, 15, 3'b001};
    vecs[5] = '{3, 0, 0, 3'b010};
    vecs[6] = '{3, 15, 15, 3'b010};

    // Reset held with random inputs
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_valid = N'($urandom);
      req_a = (4*N)'($urandom);
      req_b = (4*N)'($urandom);
      rsp_ready = 1'($urandom);
      @(negedge clk);
      chk("reset_outs", 32'(outs()), 32'(0));
      chk("reset_fp_outs", 32'(fp_outs()), 32'(0));
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'({req_ready, busy}), 32'(0));
    @(posedge clk); #1;

    foreach (vecs[i])
      do_single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].gel);

    // Fairness: all requesters held valid
    do_reset();
    req_a = {4{4'h7}};
    req_b = {4{4'h7}};
    req_valid = '1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      e_rdy = '0;
      f_rdy = '0;
      if (k % 3 == 0) begin
        e_rdy[(k / 3) % N] = 1'b1;
        f_rdy[0] = 1'b1;
      end
      chk("rr_grant", 32'(req_ready), 32'(e_rdy));
      chk("fp_grant", 32'(fp_req_ready), 32'(f_rdy));
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(posedge clk); #1;

    // Back-pressure with another requester waiting
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_a[7:4] = 4'd9;
    req_b[7:4] = 4'd4;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'(4'b0010));
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_a[3:0] = 4'd3;
    req_b[3:0] = 4'd3;
    @(negedge clk);
    chk("bp_cmp", 32'({req_ready, busy}), 32'(5'b00001));
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_stall", 32'(outs()),
          32'({4'b0000, 1'b1, 2'd1, 3'b100, 1'b1}));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_grant", 32'({req_ready, rsp_valid, busy}),
        32'({4'b0001, 2'b00}));
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_second_rsp", 32'({rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt}),
        32'({1'b1, 2'd0, 3'b010}));
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset while the compare is in flight
    req_valid = 4'b0001;
    req_a[3:0] = 4'd15;
    req_b[3:0] = 4'd1;
    @(negedge clk);
    chk("midrst_grant", 32'(req_ready), 32'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'(outs()), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_quiet", 32'({rsp_valid, busy}), 32'(0));
      @(posedge clk); #1;
    end
    do_single(0, 15, 1, 3'b100);

    // Every operand pair through requester 3
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_single(3, a, b, ref_cmp(a, b));

    // Random requesters against the transaction model
    do_reset();
    m_ptr = 0;
    m_busy = 1'b0;
    m_age = 0;
    m_id = 0;
    m_a = 0;
    m_b = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(2) == 0) begin
          req_valid[i] = 1'b1;
          req_a[4*i +: 4] = 4'($urandom);
          req_b[4*i +: 4] = 4'($urandom);
        end
      rsp_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      g = -1;
      if (!m_busy)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      e_rdy = '0;
      if (g >= 0) e_rdy[g] = 1'b1;
      chk("rnd_ready", 32'(req_ready), 32'(e_rdy));
      chk("rnd_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 2));
      if (m_busy && m_age >= 2)
        chk("rnd_result", 32'({rsp_id, rsp_gt, rsp_eq, rsp_lt}),
            32'({W'(m_id), ref_cmp(m_a, m_b)}));
      if (rsp_valid)
        chk("rnd_onehot", 32'($countones({rsp_gt, rsp_eq, rsp_lt})), 32'(1));
      acc = req_valid & req_ready;
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1'b1;
          m_age = 1;
          m_id = g;
          m_a = int'(req_a[4*g +: 4]);
          m_b = int'(req_b[4*g +: 4]);
          m_ptr = (g + 1) % N;
        end
      end else if (m_age >= 2) begin
        if (rsp_ready) m_busy = 1'b0;
      end else begin
        m_age++;
      end
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
